jpeg_coeff_decoder: RTL and testbench

// - Parametrised Huffman coefficient decoder, next generation of the MCU coefficient stage.
// - Decodes one 8x8 block per request (DC with prediction, then AC run/size symbols) from the bit buffer.
// - Emits sparse coefficients {value, zigzag idx} to the IDCT input side and marks end of block.
// - Generalises component count, coefficient width and per-component table selection.
// - Adds output backpressure, malformed-stream detection and (optional) restart-interval DC reset.

---
 rtl/jpeg_coeff_decoder.sv | 198 +++++++++++++++++++
 tb/tb_jpeg_coeff_decoder.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_coeff_decoder.sv
// Huffman coefficient decoder for one 8x8 block per request: DC with prediction, then AC run/size symbols.
// Optional restart-interval predictor reset is compiled in when JPEG_COEFF_RESTART_EN is defined.
module jpeg_coeff_decoder #(
    parameter int NUM_COMP = 4,
    parameter int COEFF_W  = 16,
    parameter int MAX_SIZE = 11,
    localparam int CW = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      img_start_i,
`ifdef JPEG_COEFF_RESTART_EN
    input  logic                      restart_i,
`endif
    input  logic                      blk_valid_i,
    output logic                      blk_ready_o,
    input  logic [CW-1:0]             blk_comp_i,
    input  logic [1:0]                blk_dc_tbl_i,
    input  logic [1:0]                blk_ac_tbl_i,
    input  logic                      inport_valid_i,
    input  logic [31:0]               inport_data_i,
    output logic [5:0]                inport_pop_o,
    output logic                      lookup_req_o,
    output logic [1:0]                lookup_table_o,
    output logic [15:0]               lookup_input_o,
    input  logic                      lookup_valid_i,
    input  logic [4:0]                lookup_width_i,
    input  logic [7:0]                lookup_value_i,
    output logic                      outport_valid_o,
    input  logic                      outport_ready_i,
    output logic signed [COEFF_W-1:0] outport_data_o,
    output logic [5:0]                outport_idx_o,
    output logic                      outport_eob_o,
    output logic                      error_o
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOOKUP, S_OUTPUT, S_EOB} state_t;

    localparam logic [3:0] MAX_S = 4'(MAX_SIZE);

    state_t                      state_q, state_d;
    logic [CW-1:0]               comp_q;
    logic [1:0]                  dc_tbl_q, ac_tbl_q;
    logic [5:0]                  idx_q, idx_d;
    logic                        first_q, dc_ok_q;
    logic [4:0]                  width_q;
    logic [7:0]                  sym_q;
    logic [15:0]                 bits_q;
    logic                        out_vld_q, err_q;
    logic signed [COEFF_W-1:0]   out_data_q, dc_val_q;
    logic [5:0]                  out_idx_q;
    logic signed [COEFF_W-1:0]   pred_q [NUM_COMP];

    logic                        load_out, retire, set_err;
    logic [31:0]                 lookup_shift;
    logic [3:0]                  size_w, run_w;
    logic [6:0]                  ac_idx, zrl_idx;
    logic                        is_eob, is_zrl, bad, need_push;
    logic signed [COEFF_W-1:0]   coef_val, push_data;
    logic [5:0]                  push_idx;

    // Size-s amplitude bits to signed value: leading 0 marks the negative half of the range.
    function automatic logic signed [COEFF_W-1:0] amp_to_coef(input logic [15:0] bits,
                                                              input logic [3:0]  s);
        logic [16:0] raw;
        logic [16:0] ofs;
        raw = 17'(bits) >> (5'd16 - {1'b0, s});
        ofs = (17'd1 << s) - 17'd1;
        if (s == 4'd0)
            return '0;
        if ((raw & (17'd1 << (s - 4'd1))) == 17'd0)
            raw = raw - ofs;
        return COEFF_W'(signed'(raw));
    endfunction

    assign lookup_shift = inport_data_i << lookup_width_i;
    assign size_w    = sym_q[3:0];
    assign run_w     = sym_q[7:4];
    assign ac_idx    = {1'b0, idx_q} + {3'b000, run_w} + 7'd1;
    assign zrl_idx   = {1'b0, idx_q} + 7'd16;
    assign is_eob    = !first_q && (sym_q == 8'h00);
    assign is_zrl    = !first_q && (sym_q == 8'hF0);
    assign bad       = (size_w > MAX_S) ||
                       (!first_q && !is_eob && (is_zrl ? (zrl_idx > 7'd63) : (ac_idx > 7'd63)));
    assign need_push = !bad && !is_eob && !is_zrl;
    assign coef_val  = amp_to_coef(bits_q, size_w);
    assign push_data = first_q ? (pred_q[comp_q] + coef_val) : coef_val;
    assign push_idx  = first_q ? 6'd0 : ac_idx[5:0];

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        lookup_req_o = 1'b0;
        inport_pop_o = 6'd0;
        load_out     = 1'b0;
        retire       = 1'b0;
        set_err      = 1'b0;
        case (state_q)
            S_IDLE:   if (blk_valid_i) state_d = S_FETCH;
            S_FETCH: begin
                if (inport_valid_i) begin
                    lookup_req_o = 1'b1;
                    state_d      = S_LOOKUP;
                end
            end
            S_LOOKUP: if (lookup_valid_i) state_d = S_OUTPUT;
            S_OUTPUT: begin
                if (bad) begin
                    inport_pop_o = {1'b0, width_q};
                    set_err      = 1'b1;
                    state_d      = S_EOB;
                end else if (!need_push) begin
                    inport_pop_o = {1'b0, width_q};
                    state_d      = is_eob ? S_EOB : S_FETCH;
                    if (is_zrl) idx_d = zrl_idx[5:0];
                end else if (!out_vld_q) begin
                    load_out = 1'b1;
                end else if (outport_ready_i) begin
                    retire       = 1'b1;
                    inport_pop_o = {1'b0, width_q} + {2'b00, size_w};
                    idx_d        = push_idx;
                    state_d      = (!first_q && ac_idx == 7'd63) ? S_EOB : S_FETCH;
                end
            end
            S_EOB:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // A new image overrides any in-flight block, including this cycle's consumption.
        if (img_start_i) begin
            state_d      = S_IDLE;
            lookup_req_o = 1'b0;
            inport_pop_o = 6'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || img_start_i) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            err_q      <= 1'b0;
            dc_ok_q    <= 1'b0;
            for (int i = 0; i < NUM_COMP; i++) pred_q[i] <= '0;
        end else begin
`ifdef JPEG_COEFF_RESTART_EN
            if (state_q == S_IDLE && restart_i)
                for (int i = 0; i < NUM_COMP; i++) pred_q[i] <= '0;
`endif
            if (state_q == S_IDLE && blk_valid_i) begin
                comp_q   <= blk_comp_i;
                dc_tbl_q <= blk_dc_tbl_i;
                ac_tbl_q <= blk_ac_tbl_i;
                idx_q    <= 6'd0;
                first_q  <= 1'b1;
                dc_ok_q  <= 1'b0;
            end
            if (state_q == S_LOOKUP && lookup_valid_i) begin
                width_q <= lookup_width_i;
                sym_q   <= lookup_value_i;
                bits_q  <= lookup_shift[31:16];
            end
            if (load_out) begin
                out_vld_q  <= 1'b1;
                out_data_q <= push_data;
                out_idx_q  <= push_idx;
            end
            if (retire) begin
                out_vld_q <= 1'b0;
                first_q   <= 1'b0;
                if (first_q) begin
                    dc_val_q <= push_data;
                    dc_ok_q  <= 1'b1;
                end
            end
            if (state_q == S_OUTPUT) idx_q <= idx_d;
            if (set_err) err_q <= 1'b1;
            // Predictor commits only once the whole block has been decoded.
            if (state_q == S_EOB && dc_ok_q) pred_q[comp_q] <= dc_val_q;
        end
    end

    assign blk_ready_o     = (state_q == S_IDLE);
    assign lookup_table_o  = lookup_req_o ? (first_q ? dc_tbl_q : ac_tbl_q) : 2'b00;
    assign lookup_input_o  = inport_data_i[31:16];
    assign outport_valid_o = out_vld_q;
    assign outport_data_o  = out_data_q;
    assign outport_idx_o   = out_idx_q;
    assign outport_eob_o   = (state_q == S_EOB);
    assign error_o         = err_q;

endmodule

// File: tb/tb_jpeg_coeff_decoder.sv
// Self-checking bench for jpeg_coeff_decoder: scripted bit stream and Huffman responder, block-level reference model.
module tb_jpeg_coeff_decoder;
    localparam int N = 8192;

    logic        clk = 1'b0;
    logic        rst_i, img_start_i, blk_valid_i;
    logic [1:0]  blk_comp_i, blk_dc_tbl_i, blk_ac_tbl_i;
    logic        blk_ready_o;
    logic        inport_valid_i;
    logic [31:0] inport_data_i;
    logic [5:0]  inport_pop_o;
    logic        lookup_req_o;
    logic [1:0]  lookup_table_o;
    logic [15:0] lookup_input_o;
    logic        lookup_valid_i;
    logic [4:0]  lookup_width_i;
    logic [7:0]  lookup_value_i;
    logic        outport_valid_o, outport_ready_i;
    logic signed [15:0] outport_data_o;
    logic [5:0]  outport_idx_o;
    logic        outport_eob_o, error_o;
`ifdef JPEG_COEFF_RESTART_EN
    logic        restart_i = 1'b0;
`endif

    jpeg_coeff_decoder #(.NUM_COMP(4), .COEFF_W(16), .MAX_SIZE(11)) dut (
        .clk_i(clk), .rst_i(rst_i), .img_start_i(img_start_i),
`ifdef JPEG_COEFF_RESTART_EN
        .restart_i(restart_i),
`endif
        .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_comp_i(blk_comp_i),
        .blk_dc_tbl_i(blk_dc_tbl_i), .blk_ac_tbl_i(blk_ac_tbl_i),
        .inport_valid_i(inport_valid_i), .inport_data_i(inport_data_i), .inport_pop_o(inport_pop_o),
        .lookup_req_o(lookup_req_o), .lookup_table_o(lookup_table_o), .lookup_input_o(lookup_input_o),
        .lookup_valid_i(lookup_valid_i), .lookup_width_i(lookup_width_i), .lookup_value_i(lookup_value_i),
        .outport_valid_o(outport_valid_o), .outport_ready_i(outport_ready_i),
        .outport_data_o(outport_data_o), .outport_idx_o(outport_idx_o),
        .outport_eob_o(outport_eob_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit sbits [N];
    int ptr;
    bit valid_rnd = 1'b0;
    int lk_w[$], lk_v[$], lk_t[$];
    int lk_rd, lk_err;
    int exp_d[$], exp_i[$];
    int pred [4];
    bit exp_err = 1'b0;
    int wr_pos = 0, exp_end = 0;

    // Bit buffer model: MSB of the window is the next unread stream bit.
    always_comb begin
        inport_data_i = '0;
        for (int k = 0; k < 32; k++) inport_data_i[31-k] = sbits[(ptr + k) % N];
    end

    always @(posedge clk) begin
        if (rst_i) ptr <= 0;
        else       ptr <= ptr + int'(inport_pop_o);
    end

    initial begin
        inport_valid_i = 1'b1;
        forever begin
            @(posedge clk); #2;
            inport_valid_i = valid_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Huffman table stand-in: answers each request with the next scripted symbol after 1..3 cycles.
    initial begin
        int w, v;
        lookup_valid_i = 1'b0; lookup_width_i = '0; lookup_value_i = '0;
        lk_rd = 0; lk_err = 0;
        forever begin
            @(negedge clk);
            if (!rst_i && lookup_req_o === 1'b1) begin
                if (lk_rd >= lk_w.size()) begin
                    lk_err++; w = 1; v = 0;
                end else begin
                    w = lk_w[lk_rd]; v = lk_v[lk_rd];
                    if (lookup_table_o !== 2'(lk_t[lk_rd])) lk_err++;
                    if (lookup_input_o !== inport_data_i[31:16]) lk_err++;
                    lk_rd++;
                end
                repeat (1 + $urandom_range(0, 2)) @(negedge clk);
                lookup_width_i = 5'(w); lookup_value_i = 8'(v); lookup_valid_i = 1'b1;
                @(negedge clk);
                lookup_valid_i = 1'b0;
            end
        end
    end

    function automatic int dec(input int a, input int s);
        if (s == 0) return 0;
        if (a < (1 << (s - 1))) return a - (1 << s) + 1;
        return a;
    endfunction

    task automatic put_bits(inout int pos, input int val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sbits[pos % N] = ((val >> i) & 1) != 0;
            pos++;
        end
    endtask

    task automatic emit_sym(inout int pos, input int sym, input int tbl);
        int w;
        w = $urandom_range(1, 16);
        put_bits(pos, int'($urandom), w);
        lk_w.push_back(w); lk_v.push_back(sym); lk_t.push_back(tbl);
    endtask

    // Reference model: walks the symbol list by the decoding rules, writing the stream and expectations.
    task automatic plan_block(input int comp, input int dct, input int act,
                              input int syms[$], input int amps[$], input bit term);
        int pos, idx, k, sym, s, r, amp, newp;
        bit first, done, dc_ok;
        pos = wr_pos; idx = 0; k = 0; first = 1; done = 0; dc_ok = 0; newp = 0;
        while (!done && k < syms.size()) begin
            sym = syms[k]; s = sym & 15; r = (sym >> 4) & 15;
            amp = (amps[k] < 0) ? int'($urandom & ((1 << s) - 1)) : amps[k];
            if (first) begin
                emit_sym(pos, sym, dct);
                if (s > 11) begin
                    exp_err = 1; done = 1;
                end else begin
                    newp = (pred[comp] + dec(amp, s)) & 16'hFFFF;
                    exp_d.push_back(newp); exp_i.push_back(0);
                    put_bits(pos, amp, s);
                    dc_ok = 1; first = 0;
                end
            end else begin
                emit_sym(pos, sym, act);
                if (sym == 0) done = 1;
                else if (sym == 'hF0) begin
                    if (idx + 16 > 63) begin exp_err = 1; done = 1; end
                    else idx += 16;
                end else if (s > 11 || idx + r + 1 > 63) begin
                    exp_err = 1; done = 1;
                end else begin
                    idx += r + 1;
                    exp_d.push_back(dec(amp, s) & 16'hFFFF); exp_i.push_back(idx);
                    put_bits(pos, amp, s);
                    if (idx == 63) done = 1;
                end
            end
            k++;
        end
        if (!done && term) emit_sym(pos, 0, act);
        if (dc_ok && term) pred[comp] = newp;
        exp_end = pos;
        for (int j = 0; j < 64; j++) sbits[(pos + j) % N] = 1'($urandom_range(0, 1));
        wr_pos = pos;
    endtask

    // mode 0: ready always high, 1: random ready, 2: ready held low 5 cycles per coefficient
    task automatic run_block(input int comp, input int dct, input int act, input int mode);
        bit done, hv;
        logic [15:0] hd;
        logic [5:0] hi;
        int lowc;
        done = 0; hv = 0; lowc = 0; hd = '0; hi = '0;
        @(negedge clk);
        checks++;
        if (blk_ready_o !== 1'b1) begin errors++; $display("FAIL blk_ready before request: got %b want 1", blk_ready_o); end
        blk_valid_i = 1'b1; blk_comp_i = 2'(comp); blk_dc_tbl_i = 2'(dct); blk_ac_tbl_i = 2'(act);
        outport_ready_i = 1'b0;
        @(negedge clk);
        blk_valid_i = 1'b0;
        if (!valid_rnd) begin
            checks++;
            if (lookup_req_o !== 1'b1) begin errors++; $display("FAIL first lookup latency: lookup_req=%b want 1", lookup_req_o); end
        end
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            case (mode)
                0:       outport_ready_i = 1'b1;
                1:       outport_ready_i = 1'($urandom_range(0, 1));
                default: outport_ready_i = (outport_valid_o === 1'b1) && (lowc >= 5);
            endcase
            #1;
            if (hv) begin
                checks++;
                if (outport_valid_o !== 1'b1 || outport_data_o !== hd || outport_idx_o !== hi) begin
                    errors++;
                    $display("FAIL stall stability: got v=%b d=%0d i=%0d want v=1 d=%0d i=%0d",
                             outport_valid_o, outport_data_o, outport_idx_o, hd, hi);
                end
            end
            if (outport_valid_o === 1'b1) begin
                if (outport_ready_i) begin
                    checks++;
                    if (exp_d.size() == 0) begin
                        errors++; $display("FAIL unexpected push: d=%0d i=%0d", outport_data_o, outport_idx_o);
                    end else begin
                        if (outport_data_o !== 16'(exp_d[0]) || outport_idx_o !== 6'(exp_i[0])) begin
                            errors++;
                            $display("FAIL coefficient: got d=%0d i=%0d want d=%0d i=%0d",
                                     outport_data_o, outport_idx_o, $signed(16'(exp_d[0])), exp_i[0]);
                        end
                        void'(exp_d.pop_front()); void'(exp_i.pop_front());
                    end
                    lowc = 0; hv = 0;
                end else begin
                    checks++;
                    if (inport_pop_o !== 6'd0) begin errors++; $display("FAIL pop during stall: got %0d want 0", inport_pop_o); end
                    hv = 1; hd = outport_data_o; hi = outport_idx_o; lowc++;
                end
            end else hv = 0;
            if (outport_eob_o === 1'b1) done = 1;
        end
        outport_ready_i = 1'b1;
        checks++;
        if (!done) begin errors++; $display("FAIL eob timeout: no eob pulse within 3000 cycles"); end
        checks++;
        if (exp_d.size() != 0) begin errors++; $display("FAIL missing pushes: %0d left, want 0", exp_d.size()); end
        checks++;
        if (ptr != exp_end) begin errors++; $display("FAIL bits consumed: ptr=%0d want %0d", ptr, exp_end); end
        checks++;
        if (lk_rd != lk_w.size() || lk_err != 0) begin
            errors++; $display("FAIL lookups: served %0d of %0d, bad=%0d want all served, bad=0", lk_rd, lk_w.size(), lk_err);
        end
        checks++;
        if (error_o !== exp_err) begin errors++; $display("FAIL error flag: got %b want %b", error_o, exp_err); end
        @(negedge clk);
        checks++;
        if (outport_eob_o !== 1'b0 || blk_ready_o !== 1'b1) begin
            errors++; $display("FAIL after eob: eob=%b ready=%b want eob=0 ready=1", outport_eob_o, blk_ready_o);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (blk_ready_o !== 1'b1 || outport_valid_o !== 1'b0 || outport_eob_o !== 1'b0 || error_o !== 1'b0 ||
            inport_pop_o !== 6'd0 || lookup_req_o !== 1'b0 || outport_data_o !== 16'd0 || outport_idx_o !== 6'd0) begin
            errors++;
            $display("FAIL reset state: ready=%b v=%b eob=%b err=%b pop=%0d req=%b want 1,0,0,0,0,0",
                     blk_ready_o, outport_valid_o, outport_eob_o, error_o, inport_pop_o, lookup_req_o);
        end
    endtask

    task automatic test_dc_pred();
        plan_block(0, 1, 2, '{'h03, 'h00}, '{5, 0}, 1);
        run_block(0, 1, 2, 0);
        plan_block(0, 1, 2, '{'h02, 'h00}, '{1, 0}, 1);
        run_block(0, 1, 2, 0);
        plan_block(1, 3, 0, '{'h01, 'h00}, '{1, 0}, 1);
        run_block(1, 3, 0, 0);
    endtask

    task automatic test_ac_run();
        plan_block(3, 0, 1, '{'h00, 'h21, 'hF0, 'h11, 'h00}, '{0, 1, 0, 0, 0}, 1);
        run_block(3, 0, 1, 0);
    endtask

    task automatic test_backpressure();
        plan_block(2, 2, 3, '{'h05, 'h13, 'h0B, 'h00}, '{-1, -1, -1, 0}, 1);
        run_block(2, 2, 3, 2);
    endtask

    task automatic test_idx63();
        plan_block(1, 0, 0, '{'h00, 'hF0, 'hF0, 'hF0, 'hE1}, '{0, 0, 0, 0, 1}, 1);
        run_block(1, 0, 0, 0);
    endtask

    task automatic test_error();
        plan_block(0, 2, 1, '{'h00, 'hF0, 'hF0, 'hF0, 'hB1, 'hF1}, '{0, 0, 0, 0, 0, 1}, 1);
        run_block(0, 2, 1, 0);
    endtask

    task automatic test_img_start();
        bit seen;
        seen = 0;
        plan_block(2, 1, 1, '{'h05}, '{31}, 0);
        @(negedge clk);
        blk_valid_i = 1'b1; blk_comp_i = 2'd2; blk_dc_tbl_i = 2'd1; blk_ac_tbl_i = 2'd1;
        outport_ready_i = 1'b0;
        @(negedge clk);
        blk_valid_i = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (outport_valid_o === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL img_start setup: no pending output within 50 cycles"); end
        img_start_i = 1'b1; blk_valid_i = 1'b1;
        @(negedge clk);
        img_start_i = 1'b0; blk_valid_i = 1'b0;
        #1;
        checks++;
        if (outport_valid_o !== 1'b0 || blk_ready_o !== 1'b1 || error_o !== 1'b0) begin
            errors++;
            $display("FAIL img_start: v=%b ready=%b err=%b want v=0 ready=1 err=0", outport_valid_o, blk_ready_o, error_o);
        end
        outport_ready_i = 1'b1;
        exp_d.delete(); exp_i.delete();
        for (int i = 0; i < 4; i++) pred[i] = 0;
        exp_err = 0;
        wr_pos = ptr;
        plan_block(0, 0, 0, '{'h00, 'h00}, '{0, 0}, 1);
        run_block(0, 0, 0, 0);
    endtask

`ifdef JPEG_COEFF_RESTART_EN
    task automatic test_restart();
        plan_block(1, 0, 0, '{'h07, 'h00}, '{100, 0}, 1);
        run_block(1, 0, 0, 0);
        @(negedge clk);
        restart_i = 1'b1;
        @(negedge clk);
        restart_i = 1'b0;
        for (int i = 0; i < 4; i++) pred[i] = 0;
        plan_block(1, 0, 0, '{'h00, 'h00}, '{0, 0}, 1);
        run_block(1, 0, 0, 0);
    endtask
`endif

    task automatic test_random();
        int syms[$], amps[$], r;
        valid_rnd = 1'b1;
        for (int b = 0; b < 30; b++) begin
            syms.delete(); amps.delete();
            r = $urandom_range(0, 99);
            syms.push_back(r < 4 ? $urandom_range(12, 15) : $urandom_range(0, 11));
            amps.push_back(-1);
            for (int k = 0; k < 64; k++) begin
                r = $urandom_range(0, 99);
                if (r < 10)      syms.push_back('h00);
                else if (r < 16) syms.push_back('hF0);
                else if (r < 18) syms.push_back(($urandom_range(0, 15) << 4) | $urandom_range(12, 15));
                else             syms.push_back(($urandom_range(0, 4) << 4) | $urandom_range(1, 11));
                amps.push_back(-1);
            end
            r = $urandom_range(0, 3);
            plan_block(r, b % 4, (b / 4) % 4, syms, amps, 1);
            run_block(r, b % 4, (b / 4) % 4, 1);
        end
        valid_rnd = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) pred[i] = 0;
        for (int i = 0; i < N; i++) sbits[i] = 1'($urandom_range(0, 1));
        rst_i = 1'b1; img_start_i = 1'b0; blk_valid_i = 1'b0;
        blk_comp_i = '0; blk_dc_tbl_i = '0; blk_ac_tbl_i = '0; outport_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        test_reset();
        test_dc_pred();
        test_ac_run();
        test_backpressure();
        test_idx63();
        test_error();
        test_img_start();
`ifdef JPEG_COEFF_RESTART_EN
        test_restart();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
